// File: rtl/mem_rf_defs.sv
// Shared definitions for the multiport register file: FSM encodings and init fill modes.
package mem_rf_defs;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } rf_state_e;

    localparam int unsigned INIT_ZERO  = 0;
    localparam int unsigned INIT_INDEX = 1;

endpackage

// File: rtl/mem_rf_init_seq.sv
// Reset-driven initialisation sequencer: sweeps every word once after rst, then idles.
module mem_rf_init_seq
    import mem_rf_defs::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned INIT_MODE = INIT_INDEX
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic [DW-1:0] init_data,
    output logic          init_busy
);

    rf_state_e     state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                ST_IDLE: state_q <= ST_IDLE;
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign init_we   = busy_q;
    assign init_addr = cnt_q;
    assign init_data = (INIT_MODE == INIT_INDEX) ? DW'(cnt_q) : '0;
    assign init_busy = busy_q;

endmodule

// File: rtl/mem_multiport_rf.sv
// Parametrised NRD-read / 1-write register file with byte enables, init sweep and range checks.
// Define MEM_RF_FWD_EN to forward same-cycle write data to matching read ports.
module mem_multiport_rf
    import mem_rf_defs::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned NRD       = 2,
    parameter int unsigned INIT_MODE = INIT_INDEX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [DW/8-1:0]   wr_be,
    output logic              init_busy,
    output logic              addr_err
);

    localparam int unsigned NB = DW / 8;

    if (DW % 8 != 0) begin : g_bad_dw
        $error("mem_multiport_rf: DW must be a multiple of 8");
    end
    if ((64'(1) << AW) < 64'(DEPTH)) begin : g_bad_aw
        $error("mem_multiport_rf: 2**AW must be >= DEPTH");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("mem_multiport_rf: NRD must be in 1..4");
    end

    logic [DW-1:0]     mem_q [DEPTH];
    logic [NRD*DW-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              addr_err_q, addr_err_d;

    logic              init_we;
    logic [AW-1:0]     init_addr;
    logic [DW-1:0]     init_data;
    logic              init_busy_w;
    logic              wr_in_range_c;
    logic              wr_ok_c;
    logic [AW-1:0]     ra_c;
    logic [DW-1:0]     word_c;

    mem_rf_init_seq #(
        .DW        (DW),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_MODE (INIT_MODE)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .init_busy (init_busy_w)
    );

    assign wr_in_range_c = 32'(wr_addr) < DEPTH;
    assign wr_ok_c       = wr_en & ~init_busy_w & wr_in_range_c;

    // Init sweep owns the write port while busy; rst itself never writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_we) begin
                mem_q[init_addr] <= init_data;
            end else if (wr_ok_c) begin
                for (int unsigned j = 0; j < NB; j++) begin
                    if (wr_be[j]) mem_q[wr_addr][8*j +: 8] <= wr_data[8*j +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        ra_c       = '0;
        word_c     = '0;
        if (!init_busy_w) begin
            if (rd_en) begin
                rd_valid_d = 1'b1;
                for (int unsigned k = 0; k < NRD; k++) begin
                    ra_c   = rd_addr[k*AW +: AW];
                    word_c = '0;
                    if (32'(ra_c) < DEPTH) begin
                        word_c = mem_q[ra_c];
`ifdef MEM_RF_FWD_EN
                        if (wr_en && (ra_c == wr_addr)) begin
                            for (int unsigned j = 0; j < NB; j++) begin
                                if (wr_be[j]) word_c[8*j +: 8] = wr_data[8*j +: 8];
                            end
                        end
`endif
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    rd_data_d[k*DW +: DW] = word_c;
                end
            end
            if (wr_en && !wr_in_range_c) addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign addr_err  = addr_err_q;
    assign init_busy = init_busy_w;

endmodule

// File: doc/mem_multiport_rf.md
Name: mem_multiport_rf

Overview:
- Parametrised register-file memory. Successor to the fixed 32x32, two-read/one-write data memory.
- Generalised in data width, depth and number of read ports.
- Adds:
  - byte-enabled writes;
  - a reset-driven initialisation sequencer;
  - out-of-range address detection;
  - optional write-to-read forwarding.
- Sits between the datapath ALU/control and the writeback stage. All ports are synchronous to one clock.

Parameters:
- DW, 32, data word width in bits. Must be a multiple of 8.
- DEPTH, 32, number of words. Need not be a power of 2.
- AW, 5, address width in bits. Must satisfy 2**AW >= DEPTH.
- NRD, 2, number of independent read ports, 1..4.
- INIT_MODE, 1, initialisation fill: 0 = all zeros, 1 = MEM[i] = i (zero-extended to DW).

Ports:
- clk  in  1  clock. All state updates on posedge.
- rst  in  1  synchronous, active-high reset. Starts the init sequence.
- rd_en  in  1  read request, common to all read ports.
- rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*DW  packed registered read data; port k uses bits [k*DW +: DW].
- rd_valid  out  1  rd_data was updated this cycle.
- wr_en  in  1  write request.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- wr_be  in  DW/8  byte enables; bit j covers byte [8j+7:8j].
- init_busy  out  1  init sequence in progress; reads and writes are ignored.
- addr_err  out  1  one-cycle pulse: an accepted access used an address >= DEPTH.

Behaviour:
- Reset (rst=1 at posedge):
  - state <= INIT, init counter <= 0;
  - rd_data <= 0, rd_valid <= 0, addr_err <= 0, init_busy <= 1.
  - Reset asserted mid-INIT or mid-operation restarts the counter at 0.
  - Memory contents are not cleared by rst itself; the INIT sweep overwrites them.
- State machine, two states:
  - INIT:
    - each cycle writes MEM[cnt] = (INIT_MODE ? cnt : 0), then cnt++;
    - after writing cnt = DEPTH-1, next state is IDLE and init_busy drops to 0;
    - total DEPTH cycles after rst deasserts.
  - IDLE: normal operation. Stays in IDLE until rst.
- In INIT:
  - rd_en and wr_en are ignored;
  - rd_valid stays 0;
  - addr_err stays 0.
- Read, IDLE:
  - rd_en=1 at posedge N: rd_data[k] = MEM[rd_addr[k]] and rd_valid=1 after posedge N (1-cycle latency).
  - rd_en=0: rd_data holds its previous value and rd_valid=0.
  - Port k with rd_addr[k] >= DEPTH: returns 0 on that port and pulses addr_err. Other ports are unaffected.
- Write, IDLE:
  - wr_en=1 at posedge: for each j with wr_be[j]=1, MEM[wr_addr] byte j <= wr_data byte j. Other bytes are unchanged.
  - wr_be = 0 is a legal no-op.
  - wr_addr >= DEPTH: write dropped, addr_err pulses.
- Simultaneous read and write, same address, same cycle:
  - without forwarding, the read returns the pre-write value;
  - with forwarding, see Optional Feature.
- Multiple read ports may use the same address; all receive identical data.
- addr_err is a single OR over all read and write range violations in that cycle.

Optional Feature:
- Macro: MEM_RF_FWD_EN.
- Defined:
  - when wr_en=1, rd_en=1 and rd_addr[k]==wr_addr (< DEPTH) in the same cycle, rd_data[k] returns the merged word: enabled bytes from wr_data, remaining bytes from MEM.
  - this gives write-then-read semantics, replacing the older negedge-write scheme.
- Undefined:
  - the read returns the old contents (read-before-write);
  - no forwarding mux is synthesised.

Decomposition:
- Shared package/include mem_rf_defs:
  - state encodings ST_INIT, ST_IDLE;
  - INIT_ZERO=0, INIT_INDEX=1.
- Parameter legality checks (DW%8==0, 2**AW>=DEPTH, 1<=NRD<=4) go in an initial block using $error.
- One natural sub-module, mem_rf_init_seq:
  - owns the FSM and counter;
  - outputs init_we, init_addr, init_data and init_busy;
  - the top muxes init_* ahead of the user write port.

Test Plan:
- Init index: rst 1 cycle, DW=32, DEPTH=32, INIT_MODE=1 -> init_busy high exactly 32 cycles. Afterwards, rd_en with addr {7,31} -> rd_data {7,31}, rd_valid=1 one cycle later.
- Byte write: wr_addr=5, wr_data=0xAABBCCDD, wr_be=4'b0101, after init -> later read of addr 5 returns 0x00BB00DD (index fill 5 -> 0x000000_05 low byte overwritten to 0xDD).
- Same-cycle R/W: wr_addr=3, wr_data=0x12345678, wr_be=4'hF, rd_addr0=3 same cycle -> rd_data0=0x00000003 without MEM_RF_FWD_EN, 0x12345678 with it. Next read returns 0x12345678 in both builds.
- Range error: DEPTH=24, AW=5, rd_addr1=30 -> rd_data1=0, addr_err pulse 1 cycle, port 0 data correct. wr_addr=28 -> write dropped, addr_err pulse.
- Reset mid-init: assert rst at init cycle 10 -> counter restarts, init_busy stays high a further DEPTH cycles. wr_en during INIT is ignored (verified by readback of the index value).
- Hold: rd_en=0 for 5 cycles after a read -> rd_data unchanged, rd_valid=0 every cycle.
